hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It compares register usage in D against producers in E/M/W using Tuse/Tnew timing. From that it drives the stall inputs of the PC and IF/ID register, the E-stage flush, and all forwarding-mux selects. It also owns the multiply/divide busy sequencer and a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, forwarding selects, md sequencer, stall counter
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  A3_E,
    input  logic [1:0]  Tnew_E,
    input  logic        start_E,
    input  logic        md_op_E,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Tnew_M,
    input  logic [4:0]  A3_W,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [1:0]  FwdRsD,
    output logic [1:0]  FwdRtD,
    output logic [1:0]  FwdRsE,
    output logic [1:0]  FwdRtE,
    output logic        FwdRtM,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall;

    // Register 0 is hardwired zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] a3);
        return (r != 5'd0) && (r == a3);
    endfunction

    // D-stage select: the youngest ready producer wins (E > M > W).
    function automatic logic [1:0] fwd_d(input logic [4:0] r);
        if (reg_hit(r, A3_E) && (Tnew_E == 2'd0))
            return 2'd1;
        else if (reg_hit(r, A3_M) && (Tnew_M == 2'd0))
            return 2'd2;
        else if (reg_hit(r, A3_W))
            return 2'd3;
        else
            return 2'd0;
    endfunction

    // E-stage select: only M and W can feed the ALU inputs.
    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (reg_hit(r, A3_M) && (Tnew_M == 2'd0))
            return 2'd2;
        else if (reg_hit(r, A3_W))
            return 2'd3;
        else
            return 2'd0;
    endfunction

    // Stall when an operand is needed sooner than its producer can deliver it,
    // or when a md instruction meets a busy or just-starting md unit.
    always_comb begin
        stall_rs = (reg_hit(rs_D, A3_E) && (Tuse_rs_D < Tnew_E)) ||
                   (reg_hit(rs_D, A3_M) && (Tuse_rs_D < Tnew_M));
        stall_rt = (reg_hit(rt_D, A3_E) && (Tuse_rt_D < Tnew_E)) ||
                   (reg_hit(rt_D, A3_M) && (Tuse_rt_D < Tnew_M));
        stall_md = md_use_D && (md_busy || start_E);
        stall    = stall_rs || stall_rt || stall_md;
        StallF   = stall;
        StallD   = stall;
        FlushE   = stall;
    end

    // Forwarding mux selects for D, E and M consumers.
    always_comb begin
        FwdRsD = fwd_d(rs_D);
        FwdRtD = fwd_d(rt_D);
        FwdRsE = fwd_e(rs_E);
        FwdRtE = fwd_e(rt_E);
        FwdRtM = reg_hit(rt_M, A3_W);
    end

    // Next count: load on start when idle, otherwise run down to zero.
    always_comb begin
        cnt_next = cnt;
        if (cnt == 4'd0) begin
            if (start_E)
                cnt_next = md_op_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else begin
            cnt_next = cnt - 4'd1;
        end
    end

    // Md sequencer state with busy flag registered from the next count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            md_busy <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            md_busy <= (cnt_next != 4'd0);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= 32'd0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D;
    logic        md_use_D;
    logic [4:0]  rs_E, rt_E, A3_E;
    logic [1:0]  Tnew_E;
    logic        start_E, md_op_E;
    logic [4:0]  rt_M, A3_M;
    logic [1:0]  Tnew_M;
    logic [4:0]  A3_W;
    logic        StallF, StallD, FlushE;
    logic [1:0]  FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic        FwdRtM;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .md_use_D(md_use_D),
        .rs_E(rs_E), .rt_E(rt_E), .A3_E(A3_E), .Tnew_E(Tnew_E),
        .start_E(start_E), .md_op_E(md_op_E),
        .rt_M(rt_M), .A3_M(A3_M), .Tnew_M(Tnew_M), .A3_W(A3_W),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .FwdRsD(FwdRsD), .FwdRtD(FwdRtD), .FwdRsE(FwdRsE), .FwdRtE(FwdRtE),
        .FwdRtM(FwdRtM), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3; md_use_D = 0;
        rs_E = 0; rt_E = 0; A3_E = 0; Tnew_E = 0; start_E = 0; md_op_E = 0;
        rt_M = 0; A3_M = 0; Tnew_M = 0; A3_W = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin errors++; $display("FAIL reset_stall: got %b want 000", {StallF, StallD, FlushE}); end
        checks++;
        if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin errors++; $display("FAIL reset_fwd: got %h want 0", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        clear_inputs();
        A3_E = 5'd1; Tnew_E = 2'd2; rs_D = 5'd1; Tuse_rs_D = 2'd1;
        #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin errors++; $display("FAIL load_use_stall: got %b want 111", {StallF, StallD, FlushE}); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL load_use_cnt0: got %h want 0", stall_cnt); end
        tick();
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_use_cnt1: got %h want 1", stall_cnt); end
        Tuse_rs_D = 2'd2;
        #1;
        checks++;
        if (StallF !== 1'b0) begin errors++; $display("FAIL tuse_eq_tnew: got %b want 0", StallF); end
        clear_inputs();
        A3_M = 5'd2; Tnew_M = 2'd1; rt_D = 5'd2; Tuse_rt_D = 2'd0;
        #1;
        checks++;
        if (StallD !== 1'b1) begin errors++; $display("FAIL m_stage_stall: got %b want 1", StallD); end
        clear_inputs();
        A3_E = 5'd0; Tnew_E = 2'd2; rs_D = 5'd0; Tuse_rs_D = 2'd0;
        #1;
        checks++;
        if (FlushE !== 1'b0) begin errors++; $display("FAIL r0_no_stall: got %b want 0", FlushE); end
        clear_inputs();
        rt_D = 5'd4; A3_E = 5'd4; Tnew_E = 2'd2; Tuse_rt_D = 2'd3;
        #1;
        checks++;
        if (StallF !== 1'b0) begin errors++; $display("FAIL tuse_unused: got %b want 0", StallF); end
        clear_inputs();
        #1;
    endtask

    task automatic test_forward();
        clear_inputs();
        rs_D = 5'd5; A3_M = 5'd5; Tnew_M = 2'd0; A3_W = 5'd5;
        #1;
        checks++;
        if (FwdRsD !== 2'd2) begin errors++; $display("FAIL fwd_rsd_m: got %0d want 2", FwdRsD); end
        A3_E = 5'd5; Tnew_E = 2'd0;
        #1;
        checks++;
        if (FwdRsD !== 2'd1) begin errors++; $display("FAIL fwd_rsd_e: got %0d want 1", FwdRsD); end
        Tnew_E = 2'd1;
        #1;
        checks++;
        if (FwdRsD !== 2'd2) begin errors++; $display("FAIL fwd_rsd_e_notready: got %0d want 2", FwdRsD); end
        Tnew_M = 2'd1; A3_E = 5'd0;
        #1;
        checks++;
        if (FwdRsD !== 2'd3) begin errors++; $display("FAIL fwd_rsd_w: got %0d want 3", FwdRsD); end
        clear_inputs();
        rt_D = 5'd9; A3_M = 5'd9;
        #1;
        checks++;
        if (FwdRtD !== 2'd2) begin errors++; $display("FAIL fwd_rtd_m: got %0d want 2", FwdRtD); end
        clear_inputs();
        rt_E = 5'd7; A3_W = 5'd7; rt_M = 5'd7;
        #1;
        checks++;
        if (FwdRtE !== 2'd3) begin errors++; $display("FAIL fwd_rte_w: got %0d want 3", FwdRtE); end
        checks++;
        if (FwdRtM !== 1'b1) begin errors++; $display("FAIL fwd_rtm: got %b want 1", FwdRtM); end
        rs_E = 5'd7; A3_M = 5'd7; Tnew_M = 2'd0; A3_E = 5'd7;
        #1;
        checks++;
        if (FwdRsE !== 2'd2) begin errors++; $display("FAIL fwd_rse_m: got %0d want 2", FwdRsE); end
        clear_inputs();
        A3_E = 5'd0; A3_M = 5'd0; A3_W = 5'd0;
        rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0; rt_M = 5'd0; Tuse_rs_D = 2'd0;
        Tnew_E = 2'd2;
        #1;
        checks++;
        if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, StallF} !== 10'd0)
            begin errors++; $display("FAIL fwd_r0: got %h want 0", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, StallF}); end
        clear_inputs();
        #1;
    endtask

    task automatic test_mult();
        do_reset();
        clear_inputs();
        md_use_D = 1'b1; start_E = 1'b1; md_op_E = 1'b0;
        #1;
        checks++;
        if ({StallF, md_busy} !== 2'b10) begin errors++; $display("FAIL mult_start: got %b want 10", {StallF, md_busy}); end
        tick();
        start_E = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if ({md_busy, StallF} !== 2'b11) begin errors++; $display("FAIL mult_busy_%0d: got %b want 11", i, {md_busy, StallF}); end
            tick();
        end
        checks++;
        if ({md_busy, StallF} !== 2'b00) begin errors++; $display("FAIL mult_done: got %b want 00", {md_busy, StallF}); end
        checks++;
        if (stall_cnt !== 32'd6) begin errors++; $display("FAIL mult_stall_cnt: got %0d want 6", stall_cnt); end
        md_use_D = 1'b0;
    endtask

    task automatic test_div_reset();
        int n;
        do_reset();
        clear_inputs();
        start_E = 1'b1; md_op_E = 1'b1;
        tick();
        start_E = 1'b0;
        n = 0;
        while (md_busy === 1'b1 && n < 30) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL div_busy_len: got %0d want 10", n); end
        do_reset();
        clear_inputs();
        md_use_D = 1'b1; start_E = 1'b1; md_op_E = 1'b1;
        tick();
        start_E = 1'b0;
        // both a data hazard and the md hazard in one cycle: one count only
        A3_E = 5'd3; Tnew_E = 2'd2; rs_D = 5'd3; Tuse_rs_D = 2'd0;
        tick();
        A3_E = 5'd0; rs_D = 5'd0;
        tick();
        tick();
        checks++;
        if ({md_busy, stall_cnt} !== {1'b1, 32'd4}) begin errors++; $display("FAIL div_mid: got busy=%b cnt=%0d want busy=1 cnt=4", md_busy, stall_cnt); end
        reset = 1'b0;
        #1;
        checks++;
        if ({md_busy, stall_cnt} !== {1'b0, 32'd0}) begin errors++; $display("FAIL div_async_reset: got busy=%b cnt=%0d want 0", md_busy, stall_cnt); end
        checks++;
        if (StallF !== 1'b0) begin errors++; $display("FAIL div_reset_stall: got %b want 0", StallF); end
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        clear_inputs();
        A3_E = 5'd1; Tnew_E = 2'd2; rs_D = 5'd1; Tuse_rs_D = 2'd1;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        #1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_%0d: got %h want ffffffff", i, stall_cnt); end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_mult();
        test_div_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
